prefetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction decoder. Generates sequential

---
 rtl/prefetch_unit_pkg.sv | 25 ++
 rtl/prefetch_unit_fifo.sv | 59 +++++
 rtl/prefetch_unit.sv | 123 ++++++++++++
 tb/tb_prefetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_unit_pkg.sv
// Shared constants and entry-layout helpers for the prefetch unit.
// PREFETCH_IBUS_ERR_EN adds a bus-error bit to every queue entry.
`ifndef PFU_INS_RANGE
`define PFU_INS_RANGE 31:0
`endif

package prefetch_unit_pkg;

  localparam int unsigned INS_W = 32;
`ifdef PREFETCH_IBUS_ERR_EN
  localparam int unsigned ERR_W = 1;
`else
  localparam int unsigned ERR_W = 0;
`endif

  // Queue entry layout (MSB first): {[err], pc, ins}
  function automatic int unsigned entry_w(input int unsigned xlen);
    return xlen + INS_W + ERR_W;
  endfunction

  function automatic int unsigned err_bit(input int unsigned xlen);
    return xlen + INS_W;
  endfunction

endpackage

// File: rtl/prefetch_unit_fifo.sv
// Synchronous FIFO with flush, holding fetched {pc, ins} entries for decode.
// The head entry is presented combinationally from storage; flush wins over push/pop.
module prefetch_fifo #(
  parameter int unsigned C_WIDTH = 64,
  parameter int unsigned C_DEPTH = 4,
  localparam int unsigned CNT_W  = $clog2(C_DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [C_WIDTH-1:0] data_i,
  output logic [C_WIDTH-1:0] head_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(C_DEPTH);

  logic [C_WIDTH-1:0] mem_q [C_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push_c, do_pop_c;

  assign do_push_c = push_i && !flush_i;
  assign do_pop_c  = pop_i && !flush_i && (count_q != '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(C_DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) mem_q[wr_ptr_q] <= data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch stage: sequential fetch, in-order response queue, redirect flush.
// Optional PREFETCH_IBUS_ERR_EN stores a bus error per entry and halts fetch until a jump.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned       C_XLEN       = 32,
  parameter int unsigned       C_FIFO_DEPTH = 4,
  parameter logic [C_XLEN-1:0] C_RESET_VEC  = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              jump_i,
  input  logic [C_XLEN-1:0] jump_addr_i,
  output logic              ibus_req_o,
  input  logic              ibus_ack_i,
  output logic [C_XLEN-1:0] ibus_addr_o,
  input  logic              ibus_rvalid_i,
  input  logic [31:0]       ibus_rdata_i,
  output logic              ids_vld_o,
  input  logic              ids_rdy_i,
  output logic [31:0]       ids_ins_o,
  output logic [C_XLEN-1:0] ids_pc_o
`ifdef PREFETCH_IBUS_ERR_EN
  ,
  input  logic              ibus_rerr_i,
  output logic              ids_err_o
`endif
);

  localparam int unsigned CNT_W   = $clog2(C_FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = entry_w(C_XLEN);

  logic [C_XLEN-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, jump_tgt_c;
  logic [CNT_W-1:0]   outs_q, outs_d, disc_q, disc_d, count_c;
  logic               run_q;
  logic               credit_ok_c, fire_c, push_c, pop_c, blocked_c;
  logic [ENTRY_W-1:0] push_data_c, head_c;
  logic               unused_addr_bits_c;

  assign unused_addr_bits_c = ^jump_addr_i[1:0];
  assign jump_tgt_c = {jump_addr_i[C_XLEN-1:2], 2'b00};

  // Never request more than the queue can absorb, counting in-flight responses.
  assign credit_ok_c = ((CNT_W+1)'(count_c) + (CNT_W+1)'(outs_q)) < (CNT_W+1)'(C_FIFO_DEPTH);
  assign ibus_req_o  = run_q && !jump_i && credit_ok_c && !blocked_c;
  assign ibus_addr_o = fetch_pc_q;
  assign fire_c      = ibus_req_o && ibus_ack_i;

  assign push_c    = ibus_rvalid_i && !jump_i && (disc_q == '0);
  assign ids_vld_o = (count_c != '0) && !jump_i;
  assign pop_c     = ids_vld_o && ids_rdy_i;
  assign ids_ins_o = head_c[INS_W-1:0];
  assign ids_pc_o  = head_c[INS_W +: C_XLEN];

`ifdef PREFETCH_IBUS_ERR_EN
  logic err_lock_q, err_lock_d;
  assign blocked_c   = err_lock_q;
  assign push_data_c = {ibus_rerr_i, resp_pc_q, ibus_rdata_i[`PFU_INS_RANGE]};
  assign ids_err_o   = head_c[err_bit(C_XLEN)];

  always_comb begin
    err_lock_d = err_lock_q;
    if (jump_i)                     err_lock_d = 1'b0;
    else if (push_c && ibus_rerr_i) err_lock_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_lock_q <= 1'b0;
    else         err_lock_q <= err_lock_d;
  end
`else
  assign blocked_c   = 1'b0;
  assign push_data_c = {resp_pc_q, ibus_rdata_i[`PFU_INS_RANGE]};
`endif

  // A redirect makes every request still in flight stale, including this cycle's response.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outs_d     = outs_q + CNT_W'(fire_c) - CNT_W'(ibus_rvalid_i);
    disc_d     = disc_q;
    if (jump_i) begin
      fetch_pc_d = jump_tgt_c;
      resp_pc_d  = jump_tgt_c;
      disc_d     = outs_d;
    end else begin
      if (fire_c) fetch_pc_d = fetch_pc_q + C_XLEN'(4);
      if (push_c) resp_pc_d  = resp_pc_q + C_XLEN'(4);
      if (ibus_rvalid_i && (disc_q != '0)) disc_d = disc_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q <= C_RESET_VEC;
      resp_pc_q  <= C_RESET_VEC;
      outs_q     <= '0;
      disc_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outs_q     <= outs_d;
      disc_q     <= disc_d;
      run_q      <= 1'b1;
    end
  end

  prefetch_fifo #(
    .C_WIDTH (ENTRY_W),
    .C_DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (jump_i),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (push_data_c),
    .head_o  (head_c),
    .count_o (count_c)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: queue-level reference model plus in-order bus model.
// Define PREFETCH_IBUS_ERR_EN to also exercise the bus-error entry bit.
module tb_prefetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0;

  logic        clk = 1'b0;
  logic        reset_i, jump_i, ibus_req_o, ibus_ack_i, ibus_rvalid_i;
  logic        ids_vld_o, ids_rdy_i;
  logic [31:0] jump_addr_i, ibus_addr_o, ibus_rdata_i, ids_ins_o, ids_pc_o;
`ifdef PREFETCH_IBUS_ERR_EN
  logic        ibus_rerr_i, ids_err_o;
`endif

  always #5 clk = ~clk;

  prefetch_unit #(.C_XLEN(32), .C_FIFO_DEPTH(DEPTH), .C_RESET_VEC(RVEC)) dut (
    .clk_i(clk), .reset_i(reset_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .ibus_req_o(ibus_req_o), .ibus_ack_i(ibus_ack_i), .ibus_addr_o(ibus_addr_o),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .ids_vld_o(ids_vld_o), .ids_rdy_i(ids_rdy_i), .ids_ins_o(ids_ins_o), .ids_pc_o(ids_pc_o)
`ifdef PREFETCH_IBUS_ERR_EN
    , .ibus_rerr_i(ibus_rerr_i), .ids_err_o(ids_err_o)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Bus model: in-order responses, each at least lat cycles after acceptance
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc, lat_min, lat_max, dut_inflight;
  bit          err_en;
  logic [31:0] err_addr;
  bit          g_fire;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_fetch, m_resp;
  int          m_outs, m_disc;
  bit          m_run, m_lock;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic apply_reset();
    reset_i = 1'b1; jump_i = 1'b0; jump_addr_i = '0; ibus_ack_i = 1'b0;
    ibus_rvalid_i = 1'b0; ibus_rdata_i = '0; ids_rdy_i = 1'b0;
`ifdef PREFETCH_IBUS_ERR_EN
    ibus_rerr_i = 1'b0;
`endif
    #1;
    checks++; if (ibus_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", ibus_req_o); end
    checks++; if (ibus_addr_o !== RVEC) begin errors++; $display("FAIL rst_addr got=%h exp=%h", ibus_addr_o, RVEC); end
    checks++; if (ids_vld_o !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b exp=0", ids_vld_o); end
    checks++; if (ids_ins_o !== 32'h0) begin errors++; $display("FAIL rst_ins got=%h exp=0", ids_ins_o); end
    checks++; if (ids_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", ids_pc_o); end
`ifdef PREFETCH_IBUS_ERR_EN
    checks++; if (ids_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", ids_err_o); end
`endif
    pend_addr.delete(); pend_due.delete(); dut_inflight = 0; cyc = 0;
    mq.delete(); m_fetch = RVEC; m_resp = RVEC; m_outs = 0; m_disc = 0; m_run = 0; m_lock = 0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  // One bus cycle: drive at negedge, check at negedge+1, then advance bus and model.
  task automatic step(input bit jmp, input logic [31:0] jaddr, input bit ack, input bit rdy);
    bit          e_req, e_vld, rv, rerr;
    logic [31:0] ra;
    int          due;
    @(negedge clk);
    rv   = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    ra   = rv ? pend_addr[0] : 32'h0;
    rerr = rv && err_en && (ra == err_addr);
    jump_i = jmp; jump_addr_i = jaddr; ibus_ack_i = ack; ids_rdy_i = rdy;
    ibus_rvalid_i = rv; ibus_rdata_i = rv ? ins_of(ra) : $urandom;
`ifdef PREFETCH_IBUS_ERR_EN
    ibus_rerr_i = rerr;
`endif
    #1;
    e_req = m_run && !jmp && !m_lock && (mq.size() + m_outs < DEPTH);
    e_vld = (mq.size() != 0) && !jmp;
    checks++;
    if (ibus_req_o !== e_req) begin errors++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, ibus_req_o, e_req); end
    if (e_req) begin
      checks++;
      if (ibus_addr_o !== m_fetch) begin errors++; $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, ibus_addr_o, m_fetch); end
    end
    checks++;
    if (ids_vld_o !== e_vld) begin errors++; $display("FAIL vld cyc=%0d got=%b exp=%b", cyc, ids_vld_o, e_vld); end
    if (e_vld) begin
      checks++;
      if (ids_pc_o !== mq[0].pc) begin errors++; $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, ids_pc_o, mq[0].pc); end
      checks++;
      if (ids_ins_o !== mq[0].ins) begin errors++; $display("FAIL ins cyc=%0d got=%h exp=%h", cyc, ids_ins_o, mq[0].ins); end
`ifdef PREFETCH_IBUS_ERR_EN
      checks++;
      if (ids_err_o !== mq[0].err) begin errors++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, ids_err_o, mq[0].err); end
`endif
    end
    // Credit rule: queued plus in-flight never exceeds the queue depth
    checks++;
    if (mq.size() + dut_inflight > DEPTH) begin
      errors++; $display("FAIL credit cyc=%0d queued=%0d inflight=%0d depth=%0d", cyc, mq.size(), dut_inflight, DEPTH);
    end
    if (rv) begin void'(pend_addr.pop_front()); void'(pend_due.pop_front()); dut_inflight--; end
    g_fire = (ibus_req_o === 1'b1) && ack;
    if (g_fire) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (pend_due.size() > 0 && pend_due[$] > due) due = pend_due[$];
      pend_addr.push_back(ibus_addr_o); pend_due.push_back(due); dut_inflight++;
    end
    if (rv) m_outs--;
    if (jmp) begin
      mq.delete();
      m_fetch = jaddr & 32'hFFFF_FFFC; m_resp = m_fetch;
      m_disc = m_outs; m_lock = 0;
    end else begin
      if (e_vld && rdy) void'(mq.pop_front());
      if (rv) begin
        if (m_disc > 0) m_disc--;
        else begin
          mq.push_back('{pc: m_resp, ins: ins_of(m_resp), err: rerr});
          m_resp += 32'd4;
          if (rerr) m_lock = 1;
        end
      end
      if (e_req && ack) begin m_fetch += 32'd4; m_outs++; end
    end
    m_run = 1;
    cyc++;
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1; err_en = 0; err_addr = '0;
    apply_reset();
  endtask

  task automatic test_stream();
    int first_vld;
    first_vld = -1;
    apply_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (first_vld < 0 && ids_vld_o === 1'b1) first_vld = cyc - 1;
    end
    checks++;
    if (first_vld != 3) begin errors++; $display("FAIL first_vld_cycle got=%0d exp=3", first_vld); end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    apply_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (g_fire) nreq++;
    end
    checks++;
    if (nreq != int'(DEPTH)) begin errors++; $display("FAIL stall_reqs got=%0d exp=%0d", nreq, DEPTH); end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic expect_first_pc(input string name, input logic [31:0] pc);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (ids_vld_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s timeout waiting for ids_vld_o", name); end
    else if (ids_pc_o !== pc) begin errors++; $display("FAIL %s got=%h exp=%h", name, ids_pc_o, pc); end
  endtask

  task automatic test_jump();
    apply_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (dut_inflight != 3) begin errors++; $display("FAIL inflight_before_jump got=%0d exp=3", dut_inflight); end
    step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (ibus_addr_o !== 32'h100) begin errors++; $display("FAIL jump_addr got=%h exp=00000100", ibus_addr_o); end
    expect_first_pc("jump_first_pc", 32'h100);
  endtask

  task automatic test_jump_pop();
    apply_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0400, 1'b1, 1'b1);
    checks++;
    if (ids_vld_o !== 1'b0) begin errors++; $display("FAIL jump_cycle_vld got=%b exp=0", ids_vld_o); end
    expect_first_pc("jump_pop_first_pc", 32'h400);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    lat_min = 2; lat_max = 3;
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0301, 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_FFF6, 1'b1, 1'b1);
    expect_first_pc("b2b_first_pc", 32'hFFFF_FFF4);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] ja;
    for (int l = 1; l <= 3; l++) begin
      apply_reset();
      lat_min = 1; lat_max = l;
      for (int i = 0; i < 250; i++) begin
        ja = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31))) : $urandom;
        step($urandom_range(99) < 8, ja, $urandom_range(99) < 70, $urandom_range(99) < 60);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (dut_inflight != 2) begin errors++; $display("FAIL inflight_before_reset got=%0d exp=2", dut_inflight); end
    @(negedge clk);
    #2;
    apply_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1);
  endtask

`ifdef PREFETCH_IBUS_ERR_EN
  task automatic test_err();
    bit seen;
    int nreq;
    seen = 0; nreq = 0;
    apply_reset();
    lat_min = 1; lat_max = 1; err_en = 1; err_addr = 32'h8;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (ids_vld_o === 1'b1 && ids_pc_o === 32'h8) seen = (ids_err_o === 1'b1);
      if (i >= 8 && g_fire) nreq++;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL err_entry8 got=0 exp=1"); end
    checks++;
    if (nreq != 0) begin errors++; $display("FAIL err_halt reqs got=%0d exp=0", nreq); end
    step(1'b1, 32'h0000_0040, 1'b1, 1'b1);
    expect_first_pc("err_resume_pc", 32'h40);
    err_en = 0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_jump_pop();
    test_back_to_back();
    test_reset_mid();
`ifdef PREFETCH_IBUS_ERR_EN
    test_err();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
